// File: rtl/fir_pkg.sv
// Shared definitions for the FIR filter: sequencer state encoding, MAC control
// bundle, default filter geometry and a constant clog2 helper.
package fir_pkg;

  localparam int FIR_DEPTH_DEF = 128;
  localparam int MAC_LAT_DEF   = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } seq_state_e;

  // Control that travels alongside a tap from address issue to the MAC input.
  typedef struct packed {
    logic last;
    logic en;
    logic clr;
  } mac_ctl_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << r) < 64'(value)) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fir_seq_delay.sv
// Enable-gated, reset-cleared shift register of parametric depth; carries the
// per-tap MAC control bits across the address-to-product latency.
module fir_seq_delay #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 3
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout
);

  logic [DEPTH-1:0][WIDTH-1:0] pipe_d;
  logic [DEPTH-1:0][WIDTH-1:0] pipe_q;

  always_comb begin
    pipe_d = pipe_q;
    if (i_en) begin
      pipe_d[0] = i_din;
      for (int i = 1; i < DEPTH; i++) begin
        pipe_d[i] = pipe_q[i-1];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign o_dout = pipe_q[DEPTH-1];

endmodule

// File: rtl/fir_mac_sequencer.sv
// Sequencer for a single-MAC time-multiplexed FIR: ring write, tap walk, MAC strobes.
// Optional sticky overrun flag built when FIR_SEQ_OVERRUN_EN is defined.
//
// state    | meaning
// IDLE     | waiting for a sample, o_din_ready high
// WRITE    | writing the sample into the ring, issuing tap 0
// RUN      | presenting tap k, issuing tap k+1 until the last tap is out
// DRAIN    | waiting for the last product to reach the accumulator
module fir_mac_sequencer
  import fir_pkg::*;
#(
  parameter  int FIR_DEPTH = FIR_DEPTH_DEF,
  parameter  int MAC_LAT   = MAC_LAT_DEF,
  localparam int ADDR_W    = clog2(FIR_DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic              i_din_valid,
  output logic              o_din_ready,
  output logic              o_smp_we,
  output logic [ADDR_W-1:0] o_smp_waddr,
  output logic [ADDR_W-1:0] o_smp_raddr,
  output logic [ADDR_W-1:0] o_coef_raddr,
  output logic              o_acc_clr,
  output logic              o_acc_en,
  output logic              o_dout_valid,
  output logic              o_busy,
  output logic              o_overrun,
  input  logic              i_ovr_clr
);

  localparam logic [ADDR_W-1:0] K_LAST = ADDR_W'(FIR_DEPTH - 1);
  localparam logic [ADDR_W-1:0] K_PEN  = ADDR_W'(FIR_DEPTH - 2);

  seq_state_e        state_d, state_q;
  logic [ADDR_W-1:0] k_d, k_q;
  logic [ADDR_W-1:0] k_nxt;
  logic [ADDR_W-1:0] base_d, base_q;
  logic [ADDR_W-1:0] wptr_d, wptr_q;
  logic [ADDR_W-1:0] raddr_d, raddr_q;
  logic [ADDR_W-1:0] coef_d, coef_q;
  logic              we_d, we_q;
  logic              dout_valid_d, dout_valid_q;
  logic              busy_d, busy_q;
  logic              ready_d, ready_q;
  mac_ctl_t          issue;
  mac_ctl_t          dly_out;
  mac_ctl_t          acc_q;
  logic [$bits(mac_ctl_t)-1:0] dly_raw;
  logic              ovr_evt;

  assign k_nxt   = k_q + ADDR_W'(1);
  assign ovr_evt = i_din_valid & (state_q != ST_IDLE);

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    base_d       = base_q;
    wptr_d       = wptr_q;
    raddr_d      = raddr_q;
    coef_d       = coef_q;
    we_d         = 1'b0;
    dout_valid_d = 1'b0;
    issue        = '0;
    case (state_q)
      ST_IDLE: begin
        if (i_din_valid) begin
          state_d = ST_WRITE;
          we_d    = 1'b1;
        end
      end
      ST_WRITE: begin
        base_d    = wptr_q;
        k_d       = '0;
        raddr_d   = wptr_q;
        coef_d    = '0;
        issue.clr = 1'b1;
        issue.en  = 1'b1;
        state_d   = ST_RUN;
      end
      ST_RUN: begin
        if (k_q == K_LAST) begin
          state_d = ST_DRAIN;
        end else begin
          k_d        = k_nxt;
          raddr_d    = base_q - k_nxt;
          coef_d     = k_nxt;
          issue.en   = 1'b1;
          issue.last = (k_q == K_PEN);
        end
      end
      ST_DRAIN: begin
        // The last tap's product reaches the accumulator on the edge ending this cycle.
        if (acc_q.last) begin
          dout_valid_d = 1'b1;
          wptr_d       = wptr_q + ADDR_W'(1);
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d  = (state_d != ST_IDLE);
    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q      <= ST_IDLE;
      k_q          <= '0;
      base_q       <= '0;
      wptr_q       <= '0;
      raddr_q      <= '0;
      coef_q       <= '0;
      we_q         <= 1'b0;
      dout_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      ready_q      <= 1'b1;
      acc_q        <= '0;
    end else if (i_en) begin
      state_q      <= state_d;
      k_q          <= k_d;
      base_q       <= base_d;
      wptr_q       <= wptr_d;
      raddr_q      <= raddr_d;
      coef_q       <= coef_d;
      we_q         <= we_d;
      dout_valid_q <= dout_valid_d;
      busy_q       <= busy_d;
      ready_q      <= ready_d;
      acc_q        <= dly_out;
    end
  end

  fir_seq_delay #(
    .DEPTH (MAC_LAT),
    .WIDTH ($bits(mac_ctl_t))
  ) u_delay (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_en   (i_en),
    .i_din  (issue),
    .o_dout (dly_raw)
  );

  assign dly_out = mac_ctl_t'(dly_raw);

`ifdef FIR_SEQ_OVERRUN_EN
  logic ovr_d, ovr_q;

  always_comb begin
    ovr_d = ovr_q;
    if (ovr_evt) begin
      ovr_d = 1'b1;
    end else if (i_ovr_clr) begin
      ovr_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      ovr_q <= 1'b0;
    end else if (i_en) begin
      ovr_q <= ovr_d;
    end
  end

  assign o_overrun = ovr_q;
`else
  logic unused_ovr;
  assign unused_ovr = i_ovr_clr ^ ovr_evt;
  assign o_overrun  = 1'b0;
`endif

  // Held strobes are masked while frozen so they replay exactly once on resume.
  assign o_smp_we     = we_q & i_en;
  assign o_acc_clr    = acc_q.clr & i_en;
  assign o_acc_en     = acc_q.en & i_en;
  assign o_dout_valid = dout_valid_q & i_en;
  assign o_smp_waddr  = wptr_q;
  assign o_smp_raddr  = raddr_q;
  assign o_coef_raddr = coef_q;
  assign o_busy       = busy_q;
  assign o_din_ready  = ready_q;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Self-checking bench for fir_mac_sequencer (FIR_DEPTH=4, MAC_LAT=2) against a
// per-sample timeline model; honours FIR_SEQ_OVERRUN_EN.
module tb_fir_mac_sequencer;

  localparam int D = 4;
  localparam int L = 2;

  logic       i_clk;
  logic       i_rst;
  logic       i_en;
  logic       i_din_valid;
  logic       i_ovr_clr;
  logic       o_din_ready;
  logic       o_smp_we;
  logic [1:0] o_smp_waddr;
  logic [1:0] o_smp_raddr;
  logic [1:0] o_coef_raddr;
  logic       o_acc_clr;
  logic       o_acc_en;
  logic       o_dout_valid;
  logic       o_busy;
  logic       o_overrun;

  fir_mac_sequencer #(.FIR_DEPTH(D), .MAC_LAT(L)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_en         (i_en),
    .i_din_valid  (i_din_valid),
    .o_din_ready  (o_din_ready),
    .o_smp_we     (o_smp_we),
    .o_smp_waddr  (o_smp_waddr),
    .o_smp_raddr  (o_smp_raddr),
    .o_coef_raddr (o_coef_raddr),
    .o_acc_clr    (o_acc_clr),
    .o_acc_en     (o_acc_en),
    .o_dout_valid (o_dout_valid),
    .o_busy       (o_busy),
    .o_overrun    (o_overrun),
    .i_ovr_clr    (i_ovr_clr)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int dv_cyc = -1;
  int we_log[$];

  // Reference: t counts enabled edges since the accepting edge of the current sample.
  bit m_active;
  int m_t;
  int m_base;
  int m_wptr;
  int m_raddr;
  int m_coef;
  bit m_dv;
  bit m_ovr;

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_t = 0; m_base = 0; m_wptr = 0;
    m_raddr = 0; m_coef = 0; m_dv = 0; m_ovr = 0;
  endtask

  task automatic model_edge();
    if (i_din_valid && m_active) m_ovr = 1;
    else if (i_ovr_clr) m_ovr = 0;
    m_dv = 0;
    if (m_active) begin
      m_t++;
      if (m_t == D + 2 + L) begin
        m_active = 0;
        m_dv     = 1;
        m_wptr   = (m_wptr + 1) % D;
      end else if (m_t >= 2 && m_t <= D + 1) begin
        m_raddr = (m_base + D - (m_t - 2)) % D;
        m_coef  = m_t - 2;
      end
    end else if (i_din_valid) begin
      m_active = 1;
      m_t      = 1;
      m_base   = m_wptr;
    end
  endtask

  task automatic check_outputs();
    bit exp_ovr;
`ifdef FIR_SEQ_OVERRUN_EN
    exp_ovr = m_ovr;
`else
    exp_ovr = 0;
`endif
    cmp("din_ready", 32'(o_din_ready), 32'(!m_active));
    cmp("busy", 32'(o_busy), 32'(m_active));
    cmp("smp_we", 32'(o_smp_we), 32'(m_active && m_t == 1 && i_en));
    cmp("smp_waddr", 32'(o_smp_waddr), 32'(m_wptr));
    cmp("smp_raddr", 32'(o_smp_raddr), 32'(m_raddr));
    cmp("coef_raddr", 32'(o_coef_raddr), 32'(m_coef));
    cmp("acc_clr", 32'(o_acc_clr), 32'(m_active && m_t == 2 + L && i_en));
    cmp("acc_en", 32'(o_acc_en), 32'(m_active && m_t >= 2 + L && m_t <= 1 + D + L && i_en));
    cmp("dout_valid", 32'(o_dout_valid), 32'(m_dv && i_en));
    cmp("overrun", 32'(o_overrun), 32'(exp_ovr));
  endtask

  task automatic tick(input bit rst, input bit en, input bit dv, input bit oc);
    i_rst = rst; i_en = en; i_din_valid = dv; i_ovr_clr = oc;
    if (!rst) model_reset();
    @(negedge i_clk);
    check_outputs();
    if (o_dout_valid) dv_cyc = cyc;
    if (o_smp_we) we_log.push_back(int'(o_smp_waddr));
    @(posedge i_clk);
    if (!i_rst) model_reset();
    else if (i_en) model_edge();
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1, 1, 0, 0);
  endtask

  task automatic do_reset();
    tick(0, 1, 0, 0);
    tick(0, 1, 0, 0);
    cyc = 0;
  endtask

  initial begin
    int p;
    i_rst = 0; i_en = 0; i_din_valid = 0; i_ovr_clr = 0;
    model_reset();

    // Quiet after reset.
    do_reset();
    idle(20);

    // Single sample: output 8 cycles after the pulse, pointer advances.
    do_reset();
    idle(10);
    p = cyc;
    dv_cyc = -1;
    we_log.delete();
    tick(1, 1, 1, 0);
    idle(12);
    cmp("single_dv_lat", 32'(dv_cyc - p), 32'(D + L + 2));
    cmp("single_we_addr", 32'(we_log.size() == 1 ? we_log[0] : -1), 32'(0));

    // Five samples at the minimum period: write pointer wraps.
    do_reset();
    idle(2);
    we_log.delete();
    for (int i = 0; i < 5; i++) begin
      tick(1, 1, 1, 0);
      idle(D + L + 1);
    end
    idle(4);
    cmp("b2b_count", 32'(we_log.size()), 32'(5));
    for (int i = 0; i < 5 && i < we_log.size(); i++) begin
      cmp("b2b_waddr", 32'(we_log[i]), 32'(i % D));
    end

    // Pulse during a run is dropped; overrun set then cleared.
    do_reset();
    idle(10);
    we_log.delete();
    dv_cyc = -1;
    p = cyc;
    tick(1, 1, 1, 0);
    idle(2);
    tick(1, 1, 1, 0);
    idle(10);
    cmp("ovr_writes", 32'(we_log.size()), 32'(1));
    cmp("ovr_dv_lat", 32'(dv_cyc - p), 32'(D + L + 2));
    tick(1, 1, 0, 1);
    idle(3);

    // Enable low for three cycles mid-run delays the output by three.
    do_reset();
    idle(10);
    dv_cyc = -1;
    p = cyc;
    tick(1, 1, 1, 0);
    idle(2);
    repeat (3) tick(1, 0, 0, 0);
    idle(10);
    cmp("en_hold_dv_lat", 32'(dv_cyc - p), 32'(D + L + 2 + 3));

    // Reset mid-run: no output, next sample writes slot 0.
    do_reset();
    idle(10);
    tick(1, 1, 1, 0);
    idle(3);
    dv_cyc = -1;
    tick(0, 1, 0, 0);
    tick(0, 1, 0, 0);
    idle(12);
    cmp("rst_no_dv", 32'(dv_cyc), 32'(-1));
    we_log.delete();
    tick(1, 1, 1, 0);
    idle(10);
    cmp("rst_next_waddr", 32'(we_log.size() == 1 ? we_log[0] : -1), 32'(0));

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      tick(($urandom % 150) != 0, ($urandom % 8) != 0,
           ($urandom % 6) == 0, ($urandom % 15) == 0);
    end
    idle(12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fir_mac_sequencer.md
# fir_mac_sequencer

Control sequencer for a time-multiplexed FIR filter. Sits between the deserializer and a single-multiplier FIR datapath (sample ring RAM, coefficient ROM, one MAC). For each new sample it writes the sample into the ring, then walks all FIR_DEPTH taps one per cycle. It times the accumulator clear/enable strobes to the datapath latency and flags the finished output sample to the serializer.

## Interface
- FIR_DEPTH, 128: number of taps; power of two, ≥ 2
- MAC_LAT, 2: cycles from address issue to product valid at accumulator input; ≥ 1
- ADDR_W (localparam), clog2(FIR_DEPTH): address width
- i_clk  in  1  clock; all logic rising-edge
- i_rst  in  1  reset, asynchronous assert, active-low
- i_en  in  1  global enable; low freezes all state and forces strobes to 0
- i_din_valid  in  1  one-cycle pulse: deserializer has a new sample
- o_din_ready  out  1  high in IDLE only
- o_smp_we  out  1  sample ring write strobe
- o_smp_waddr  out  ADDR_W  ring write address (current write pointer)
- o_smp_raddr  out  ADDR_W  ring read address
- o_coef_raddr  out  ADDR_W  coefficient read address
- o_acc_clr  out  1  load accumulator with product (first tap), delayed by MAC_LAT
- o_acc_en  out  1  accumulate product, delayed by MAC_LAT
- o_dout_valid  out  1  one-cycle pulse: accumulator holds the final sum
- o_busy  out  1  high in any state except IDLE
- o_overrun  out  1  sticky overrun flag (see Configuration)
- i_ovr_clr  in  1  clears o_overrun

## Operation
- States: IDLE → WRITE → RUN → DRAIN → IDLE.
- IDLE: on i_din_valid & i_en, go to WRITE.
- WRITE (1 cycle): o_smp_we=1; o_smp_waddr=wptr; latch base=wptr; tap counter k=0.
- RUN (FIR_DEPTH cycles): o_smp_raddr=base−k mod FIR_DEPTH (newest sample first); o_coef_raddr=k; k increments. After k=FIR_DEPTH−1, go to DRAIN.
- Issue pipeline: a MAC_LAT-deep shift register carries issue-side clr/en. o_acc_clr=1 for the tap issued with k=0. o_acc_en=1 for every issued tap.
- DRAIN (MAC_LAT cycles, counted after the last issue): in its final cycle, o_dout_valid=1, wptr increments mod FIR_DEPTH, and the state goes to IDLE.
- Address wrap: all address arithmetic is modulo FIR_DEPTH, unsigned, with natural ADDR_W overflow.
- i_din_valid outside IDLE: the sample is dropped (not written), the overrun event fires, and the sequence in progress is unaffected.
- i_din_valid with i_en low: ignored, with no overrun.
- i_en low mid-sequence: state, k, wptr and the shift register all hold. Strobes (we, clr, en, dout_valid) are forced to 0. The sequence resumes exactly where it stopped when i_en returns high.
- Reset (any time): state=IDLE, wptr=0, k=0, shift register cleared, o_overrun=0.
- Reset values of outputs: o_din_ready=1; o_smp_we=0; o_smp_waddr=0; o_smp_raddr=0; o_coef_raddr=0; o_acc_clr=0; o_acc_en=0; o_dout_valid=0; o_busy=0; o_overrun=0.

## Timing
- All outputs are registered.
- Timing with i_en held high, and i_din_valid sampled in cycle A:
  - o_smp_we in A+1.
  - Tap k is issued in cycle A+2+k.
  - o_acc_clr in A+2+MAC_LAT.
  - o_acc_en in A+2+MAC_LAT through A+1+FIR_DEPTH+MAC_LAT.
  - o_dout_valid in A+2+FIR_DEPTH+MAC_LAT.
  - o_din_ready is high again in that same cycle.
- Minimum sample period: FIR_DEPTH+MAC_LAT+2 cycles.
- The datapath requires the ring RAM to have write-to-read latency of 1 cycle: the sample written in A+1 is read in A+2.
- i_ovr_clr and an overrun event in the same cycle: the set wins.

## Configuration
- FIR_SEQ_OVERRUN_EN defined: the sticky overrun register is implemented. It sets the cycle after a dropped i_din_valid and clears on i_ovr_clr.
- FIR_SEQ_OVERRUN_EN undefined: o_overrun is tied to 0 and i_ovr_clr is ignored. The drop behaviour is unchanged.

## Structure
- Shared package fir_pkg holds:
  - the state encoding constants (IDLE, WRITE, RUN, DRAIN);
  - the clog2 function;
  - the default FIR_DEPTH and MAC_LAT values, shared with fir_filter.
- One sub-module, fir_seq_delay: a parametric-depth, enable-gated, reset-cleared shift register that carries clr/en/last to the MAC stage.

## Test plan
Run all scenarios with FIR_DEPTH=4 and MAC_LAT=2.
- Reset release, no input → o_din_ready=1, o_busy=0, and all strobes stay 0 for 20 cycles.
- Single pulse in cycle 10:
  - we in 11 with waddr=0;
  - raddr 0,3,2,1 and coef 0..3 in cycles 12–15;
  - clr in 14; en in 14–17;
  - dout_valid in 18, then waddr=1.
- Five back-to-back samples spaced 8 cycles apart → waddr takes the values 0,1,2,3,0 (wrap). The fifth run reads raddr 0,3,2,1.
- i_din_valid in cycle 13 during a run → the run is unaffected, and no write occurs. o_overrun rises in 14 with the macro defined, stays 0 without it, and clears after i_ovr_clr.
- i_en low for 3 cycles mid-RUN → addresses hold, strobes are 0, and dout_valid moves 3 cycles later (cycle 21).
- i_rst asserted at cycle 14 mid-run → outputs reach reset values immediately, with no dout_valid. The next sample writes waddr=0.
